j1_io_uart: RTL and testbench

- I/O-bus responder for the J1 CPU: a memory-mapped 8N1 UART with TX FIFO and single-entry RX holding register.
- Sits on the CPU's io_* nets in the 4000H..FFFFH I/O window and decodes an 8-byte register block at BASE_ADDR.
- Reads are zero-wait-state; writes and read side effects act on the clock edge.

---
 rtl/j1_io_pkg.sv | 21 ++
 rtl/j1_io_uart_if.sv | 11 +
 rtl/j1_sync_fifo.sv | 46 ++++
 rtl/j1_io_uart.sv | 215 +++++++++++++++++++++
 tb/tb_j1_io_uart.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O-bus UART: register offsets, STATUS bit
// positions, the common TX/RX state encoding and the divisor floor.
package j1_io_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STS_TX_FULL   = 0;
  localparam int STS_TX_IDLE   = 1;
  localparam int STS_RX_VALID  = 2;
  localparam int STS_RX_OVRUN  = 3;
  localparam int STS_RX_FRMERR = 4;
  localparam int STS_TX_DROP   = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  localparam logic [15:0] DIV_MIN = 16'd3;

endpackage

// File: rtl/j1_io_uart_if.sv
// J1 CPU I/O bus as seen by one responder in the 4000H..FFFFH window.
interface j1_io_uart_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;

  modport master (output io_rd, io_wr, io_addr, io_dout, input io_din);
  modport slave  (input io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/j1_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module j1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/j1_io_uart.sv
// Memory-mapped 8N1 UART responder for the J1 I/O bus (DATA/STATUS/DIV/CTRL).
// Define J1_IO_UART_LOOPBACK_EN to add the CTRL loopback bit.
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter int          TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  j1_io_uart_if.slave bus,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o
);
  logic        sel, wr_data, wr_div, rd_data, rd_sts;
  logic [1:0]  idx;
  logic        unused_addr0;
  logic [15:0] div_q, div_d, ctrl_rd, rd_mux;
  logic        fifo_full, fifo_empty, tx_pop, tx_idle, drop_set;
  logic [7:0]  fifo_rdata;

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half_m1;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic        rx_in, rxs, rx_wait_q, rx_wait_d, rx_load, frame_set;
  logic        rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d, drop_q, drop_d;

  assign sel          = (bus.io_addr[15:3] == BASE_ADDR[15:3]);
  assign idx          = bus.io_addr[2:1];
  assign unused_addr0 = bus.io_addr[0];
  assign wr_data      = bus.io_wr & sel & (idx == REG_DATA);
  assign wr_div       = bus.io_wr & sel & (idx == REG_DIV);
  assign rd_data      = bus.io_rd & sel & (idx == REG_DATA);
  assign rd_sts       = bus.io_rd & sel & (idx == REG_STATUS);

`ifdef J1_IO_UART_LOOPBACK_EN
  logic wr_ctrl, lb_q, lb_d;
  assign wr_ctrl    = bus.io_wr & sel & (idx == REG_CTRL);
  assign lb_d       = wr_ctrl ? bus.io_dout[0] : lb_q;
  assign rx_in      = lb_q ? txd_q : uart_rxd_i;
  assign uart_txd_o = lb_q | txd_q;
  assign ctrl_rd    = {15'd0, lb_q};
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) lb_q <= 1'b0;
    else              lb_q <= lb_d;
  end
`else
  assign rx_in      = uart_rxd_i;
  assign uart_txd_o = txd_q;
  assign ctrl_rd    = 16'd0;
`endif

  j1_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i  (sys_clk_i),
    .rst_n_i(sys_rst_n_i),
    .push_i (wr_data),
    .pop_i  (tx_pop),
    .wdata_i(bus.io_dout[7:0]),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign tx_idle  = fifo_empty & (tx_state_q == ST_IDLE);
  assign drop_set = wr_data & fifo_full & ~tx_pop;
  assign div_d    = wr_div ? ((bus.io_dout < DIV_MIN) ? DIV_MIN : bus.io_dout) : div_q;

  always_comb begin
    rd_mux = 16'h0000;
    case (idx)
      REG_DATA: rd_mux = {8'h00, rx_data_q};
      REG_STATUS: begin
        rd_mux[STS_TX_FULL]   = fifo_full;
        rd_mux[STS_TX_IDLE]   = tx_idle;
        rd_mux[STS_RX_VALID]  = rx_valid_q;
        rd_mux[STS_RX_OVRUN]  = ovr_q;
        rd_mux[STS_RX_FRMERR] = ferr_q;
        rd_mux[STS_TX_DROP]   = drop_q;
      end
      REG_DIV: rd_mux = div_q;
      default: rd_mux = ctrl_rd;
    endcase
  end
  assign bus.io_din = sel ? rd_mux : 16'h0000;

  // Transmitter: the divisor is captured per frame so DIV writes never stretch a bit mid-frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_START: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0; tx_bit_d = '0; txd_d = tx_shift_q[0]; tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_cnt_q == tx_div_q) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          txd_d = 1'b1; tx_state_d = ST_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1; tx_shift_d = tx_shift_q >> 1; txd_d = tx_shift_q[1];
        end
      end
      ST_STOP: if (tx_cnt_q == tx_div_q) tx_state_d = ST_IDLE;
      default: tx_state_d = ST_IDLE;
    endcase
    // Frame launch from IDLE, or straight out of STOP for gap-free back-to-back frames.
    if ((tx_state_q == ST_IDLE || (tx_state_q == ST_STOP && tx_cnt_q == tx_div_q)) && !fifo_empty) begin
      tx_pop = 1'b1; tx_state_d = ST_START; tx_cnt_d = '0;
      tx_shift_d = fifo_rdata; tx_div_d = div_q; txd_d = 1'b0;
    end
  end

  assign rx_sync_d  = {rx_sync_q[0], rx_in};
  assign rxs        = rx_sync_q[1];
  assign rx_half_m1 = {1'b0, rx_div_q[15:1]} + {15'd0, rx_div_q[0]} - 16'd1;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_load    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (!rxs) begin
        rx_state_d = ST_START; rx_cnt_d = '0; rx_div_d = div_q;
      end
      ST_START: if (rx_cnt_q == rx_half_m1) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_state_d = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt_q == rx_div_q) begin
        rx_cnt_d = '0; rx_shift_d = {rxs, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        else                  rx_bit_d = rx_bit_q + 3'd1;
      end
      ST_STOP:
        // A low stop bit parks here until the line recovers, so a break is not re-read as a start.
        if (rx_wait_q) begin
          if (rxs) begin rx_wait_d = 1'b0; rx_state_d = ST_IDLE; end
        end else if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d = '0;
          if (rxs) begin rx_load = 1'b1; rx_state_d = ST_IDLE; end
          else begin frame_set = 1'b1; rx_wait_d = 1'b1; end
        end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  assign rx_data_d  = rx_load ? rx_shift_q : rx_data_q;
  assign rx_valid_d = rx_load ? 1'b1 : (rd_data ? 1'b0 : rx_valid_q);
  assign ovr_d      = (rx_load & rx_valid_q & ~rd_data) ? 1'b1 : (rd_sts ? 1'b0 : ovr_q);
  assign ferr_d     = frame_set ? 1'b1 : (rd_sts ? 1'b0 : ferr_q);
  assign drop_d     = drop_set  ? 1'b1 : (rd_sts ? 1'b0 : drop_q);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      div_q      <= DEFAULT_DIV;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
      rx_sync_q  <= 2'b11;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_wait_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_wait_q  <= rx_wait_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end
endmodule

// File: tb/tb_j1_io_uart.sv
// Directed + randomized bench for j1_io_uart: bus-level register checks and a
// line-level UART model (frame builder for RX, mid-bit decoder for TX).
module tb_j1_io_uart;
  localparam logic [15:0] BASE   = 16'h4000;
  localparam logic [15:0] A_DATA = BASE;
  localparam logic [15:0] A_STS  = BASE + 16'd2;
  localparam logic [15:0] A_DIV  = BASE + 16'd4;
  localparam logic [15:0] A_CTRL = BASE + 16'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bit_p = 434;
  logic [7:0] mon_q[$];
  int mon_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  j1_io_uart_if bus_if ();

  j1_io_uart #(.BASE_ADDR(BASE), .TX_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
    .sys_clk_i  (clk),
    .sys_rst_n_i(rst_n),
    .bus        (bus_if.slave),
    .uart_rxd_i (rxd),
    .uart_txd_o (txd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus_if.io_addr = a; bus_if.io_dout = d; bus_if.io_wr = 1'b1;
    @(posedge clk); #1;
    bus_if.io_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    bus_if.io_addr = a; bus_if.io_rd = 1'b1;
    @(negedge clk);
    d = bus_if.io_din;
    @(posedge clk); #1;
    bus_if.io_rd = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    chk(tag, {16'd0, d}, {16'd0, exp});
  endtask

  // Drive one 8N1 frame (LSB first) with p clocks per bit, then idle high.
  task automatic rx_send(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (p) begin @(posedge clk); #1; end
    end
    rxd = 1'b1;
    repeat (2 * p) begin @(posedge clk); #1; end
  endtask

  task automatic wait_mon(input int n, input int budget);
    int k;
    k = 0;
    while (mon_q.size() < n && k < budget) begin @(posedge clk); k++; end
    chk("tx_frames_seen", mon_q.size(), n);
  endtask

  function automatic logic [7:0] mon_at(input int i);
    return (i < mon_q.size()) ? mon_q[i] : 8'hxx;
  endfunction

  // Line decoder: find a start edge, sample mid-bit, record byte and start cycle.
  initial begin : tx_monitor
    int p;
    int t0;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && txd === 1'b0) begin
        p = bit_p; t0 = cyc;
        repeat (p / 2) @(negedge clk);
        if (txd === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge clk);
            b[i] = txd;
          end
          repeat (p) @(negedge clk);
          if (txd === 1'b1) begin mon_q.push_back(b); mon_t.push_back(t0); end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [9:0] fr;
    logic [7:0] exp_b[$];
    logic [7:0] b, b2;
    logic [15:0] d;
    int mism;

    bus_if.io_rd = 1'b0; bus_if.io_wr = 1'b0;
    bus_if.io_addr = 16'h0000; bus_if.io_dout = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1'b1);
    rst_n = 1'b1;

    rd_chk("rst_status", A_STS, 16'h0002);
    rd_chk("rst_div", A_DIV, 16'd433);
    rd_chk("rst_ctrl", A_CTRL, 16'h0000);
    rd_chk("unselected_read", 16'h5002, 16'h0000);

    bus_wr(16'h5004, 16'h1234);
    rd_chk("unselected_write_ignored", A_DIV, 16'd433);
    bus_wr(A_DIV, 16'd1);
    rd_chk("div_floor_1", A_DIV, 16'd3);
    bus_wr(A_DIV, 16'd0);
    rd_chk("div_floor_0", A_DIV, 16'd3);
    bus_wr(A_STS, 16'h00FF);
    rd_chk("status_ro", A_STS, 16'h0002);
    bit_p = 4;

    // Clock-exact A5 frame.
    mon_q.delete(); mon_t.delete();
    bus_wr(A_DATA, 16'h00A5);
    @(negedge clk);
    chk("tx_start_delay", txd, 1'b1);
    fr = {1'b1, 8'hA5, 1'b0};
    mism = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd !== fr[i / 4]) mism++;
    end
    chk("tx_a5_wave", mism, 0);
    rd_chk("tx_idle_after_a5", A_STS, 16'h0002);
    chk("tx_a5_decoded", mon_at(0), 8'hA5);

    // FIFO fill, overflow drop and back-to-back frames.
    mon_q.delete(); mon_t.delete(); exp_b.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_b.push_back(b);
      bus_wr(A_DATA, {8'h00, b});
    end
    rd_chk("fifo_full_no_drop", A_STS, 16'h0001);
    bus_wr(A_DATA, 16'h00EE);
    rd_chk("fifo_drop_set", A_STS, 16'h0021);
    rd_chk("fifo_drop_cleared", A_STS, 16'h0001);
    wait_mon(5, 5 * 40 + 100);
    for (int i = 0; i < 5; i++) chk("tx_fifo_byte", mon_at(i), exp_b[i]);
    for (int i = 0; i < 4; i++)
      chk("tx_no_gap", (i + 1 < mon_t.size()) ? mon_t[i + 1] - mon_t[i] : -1, 40);
    repeat (8) @(posedge clk);
    rd_chk("tx_idle_after_burst", A_STS, 16'h0002);

    // RX overrun.
    rx_send(8'h3C, 1'b1, 4);
    rx_send(8'h5A, 1'b1, 4);
    rd_chk("rx_overrun_status", A_STS, 16'h000E);
    rd_chk("rx_overrun_data", A_DATA, 16'h005A);
    rd_chk("rx_valid_cleared", A_STS, 16'h0002);

    // Framing error, then glitch rejection.
    rx_send(8'($urandom), 1'b0, 4);
    rd_chk("rx_frame_err", A_STS, 16'h0012);
    rd_chk("rx_frame_err_cleared", A_STS, 16'h0002);
    @(posedge clk); #1; rxd = 1'b0;
    @(posedge clk); #1; rxd = 1'b1;
    repeat (60) @(posedge clk);
    rd_chk("rx_glitch_ignored", A_STS, 16'h0002);

    // Randomized divisor with round-trip bytes on both sides.
    for (int k = 0; k < 4; k++) begin
      int dv;
      dv = $urandom_range(3, 7);
      b  = 8'($urandom);
      b2 = 8'($urandom);
      bus_wr(A_DIV, 16'(dv));
      rd_chk("rand_div_rb", A_DIV, 16'(dv));
      bit_p = dv + 1;
      mon_q.delete(); mon_t.delete();
      bus_wr(A_DATA, {8'h00, b});
      wait_mon(1, 12 * (dv + 1) + 20);
      chk("rand_tx_byte", mon_at(0), b);
      rx_send(b2, 1'b1, dv + 1);
      rd_chk("rand_rx_byte", A_DATA, {8'h00, b2});
      rd_chk("rand_status", A_STS, 16'h0002);
    end

    bus_wr(A_DIV, 16'd3);
    bit_p = 4;
`ifdef J1_IO_UART_LOOPBACK_EN
    bus_wr(A_CTRL, 16'h0001);
    rd_chk("ctrl_lb_set", A_CTRL, 16'h0001);
    bus_wr(A_DATA, 16'h0081);
    mism = 0;
    repeat (70) begin @(negedge clk); if (txd !== 1'b1) mism++; end
    chk("lb_txd_held_high", mism, 0);
    rd_chk("lb_status", A_STS, 16'h0006);
    rd_chk("lb_data", A_DATA, 16'h0081);
    bus_wr(A_CTRL, 16'h0000);
    rd_chk("ctrl_lb_clear", A_CTRL, 16'h0000);
`else
    bus_wr(A_CTRL, 16'h0001);
    rd_chk("ctrl_absent", A_CTRL, 16'h0000);
`endif

    // Reset mid-frame: line returns high without waiting for a clock.
    bus_wr(A_DATA, 16'h0000);
    repeat (3) @(posedge clk);
    #2;
    chk("tx_low_before_reset", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_txd", txd, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_chk("rst_mid_status", A_STS, 16'h0002);
    rd_chk("rst_mid_div", A_DIV, 16'd433);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
